// File: rtl/vga_cube_dmem_sync.sv
// Transfers the cube's per-square colour codes to/from dmem: STORE dumps squares plus a
// marker word, LOAD reads them back and restores the squares only if the marker matches.
module vga_cube_dmem_sync #(
  parameter int unsigned       NUM_SQ    = 24,
  parameter int unsigned       COLOR_W   = 3,
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       BASE_ADDR = 1,
  parameter logic [DATA_W-1:0] MARKER    = DATA_W'(6),
  parameter int unsigned       RD_LAT    = 1
) (
  input  logic                        iVGA_CLK,
  input  logic                        rst,
  input  logic                        store_req,
  input  logic                        load_req,
  input  logic [NUM_SQ*COLOR_W-1:0]   sq_in,
  input  logic [DATA_W-1:0]           dmem_rdata,
  output logic [ADDR_W-1:0]           dmem_addr,
  output logic [DATA_W-1:0]           dmem_wdata,
  output logic                        dmem_we,
  output logic [NUM_SQ*COLOR_W-1:0]   sq_out,
  output logic                        sq_out_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        load_err
);

  localparam int unsigned       SQ_W   = NUM_SQ * COLOR_W;
  localparam int unsigned       CNT_W  = $clog2(NUM_SQ + RD_LAT + 1);
  localparam logic [CNT_W-1:0]  K_LAST = CNT_W'(NUM_SQ);
  localparam logic [CNT_W-1:0]  J_LAST = CNT_W'(NUM_SQ + RD_LAT);
  localparam logic [CNT_W-1:0]  LAT    = CNT_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, STORE, LOAD, FINISH} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc, cap_idx;
  logic               store_q, load_q, store_start, load_start;
  logic [SQ_W-1:0]    snap, snap_d, ld_buf, ld_buf_d;
  logic [COLOR_W-1:0] next_sq;

  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic               we_d, valid_d, busy_d, done_d, err_d;
  logic [SQ_W-1:0]    sq_out_d;

  assign store_start = store_req & ~store_q;
  assign load_start  = load_req & ~load_q;
  assign cnt_inc     = cnt + CNT_W'(1);
  assign cap_idx     = cnt - LAT;

  always_comb begin
    next_sq = '0;
    for (int unsigned i = 0; i < NUM_SQ; i++) begin
      if (cnt_inc == CNT_W'(i)) next_sq = snap[i*COLOR_W +: COLOR_W];
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    snap_d   = snap;
    ld_buf_d = ld_buf;
    addr_d   = dmem_addr;
    wdata_d  = dmem_wdata;
    we_d     = 1'b0;
    sq_out_d = sq_out;
    valid_d  = 1'b0;
    busy_d   = busy;
    done_d   = done;
    err_d    = load_err;

    case (state)
      IDLE: begin
        if (store_start) begin
          state_d = STORE;
          cnt_d   = '0;
          snap_d  = sq_in;
          we_d    = 1'b1;
          addr_d  = BASE;
          wdata_d = DATA_W'(sq_in[COLOR_W-1:0]);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          addr_d  = BASE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      STORE: begin
        if (cnt == K_LAST) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
          we_d    = 1'b1;
          addr_d  = BASE + ADDR_W'(cnt_inc);
          wdata_d = (cnt_inc == K_LAST) ? MARKER : DATA_W'(next_sq);
        end
      end

      LOAD: begin
        // cnt counts issue cycles; the word issued RD_LAT cycles ago is on dmem_rdata now.
        if (cnt >= LAT) begin
          for (int unsigned i = 0; i < NUM_SQ; i++) begin
            if (cap_idx == CNT_W'(i)) ld_buf_d[i*COLOR_W +: COLOR_W] = dmem_rdata[COLOR_W-1:0];
          end
        end
        if (cnt == J_LAST) begin
          state_d = FINISH;
          if (dmem_rdata == MARKER) begin
            sq_out_d = ld_buf;
            valid_d  = 1'b1;
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt < K_LAST) addr_d = BASE + ADDR_W'(cnt_inc);
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      store_q      <= 1'b1;
      load_q       <= 1'b1;
      snap         <= '0;
      ld_buf       <= '0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_we      <= 1'b0;
      sq_out       <= '0;
      sq_out_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      store_q      <= store_req;
      load_q       <= load_req;
      snap         <= snap_d;
      ld_buf       <= ld_buf_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      dmem_we      <= we_d;
      sq_out       <= sq_out_d;
      sq_out_valid <= valid_d;
      busy         <= busy_d;
      done         <= done_d;
      load_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_vga_cube_dmem_sync.sv
// Directed bench for vga_cube_dmem_sync: default instance plus a 54-square, RD_LAT=3 instance,
// each attached to a behavioural dmem.
module tb_vga_cube_dmem_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst, store_req, load_req;
  logic [71:0]  sq_in, a_sq_out;
  logic [31:0]  a_rdata, a_wdata;
  logic [11:0]  a_addr;
  logic         a_we, a_valid, a_busy, a_done, a_err;

  logic         b_store, b_load;
  logic [161:0] b_sq_in, b_sq_out;
  logic [31:0]  b_rdata, b_wdata;
  logic [11:0]  b_addr;
  logic         b_we, b_valid, b_busy, b_done, b_err;

  logic         pre_we;
  logic [11:0]  pre_addr;
  logic [31:0]  pre_data;

  vga_cube_dmem_sync u_a (
    .iVGA_CLK(clk), .rst(rst), .store_req(store_req), .load_req(load_req),
    .sq_in(sq_in), .dmem_rdata(a_rdata), .dmem_addr(a_addr), .dmem_wdata(a_wdata),
    .dmem_we(a_we), .sq_out(a_sq_out), .sq_out_valid(a_valid), .busy(a_busy),
    .done(a_done), .load_err(a_err)
  );

  vga_cube_dmem_sync #(.NUM_SQ(54), .BASE_ADDR(100), .RD_LAT(3)) u_b (
    .iVGA_CLK(clk), .rst(rst), .store_req(b_store), .load_req(b_load),
    .sq_in(b_sq_in), .dmem_rdata(b_rdata), .dmem_addr(b_addr), .dmem_wdata(b_wdata),
    .dmem_we(b_we), .sq_out(b_sq_out), .sq_out_valid(b_valid), .busy(b_busy),
    .done(b_done), .load_err(b_err)
  );

  logic [31:0] mem_a [0:4095];
  logic [31:0] mem_b [0:4095];
  logic [31:0] b_p0, b_p1;
  int wr_a = 0;
  int wr_b = 0;

  always @(posedge clk) begin
    if (pre_we) mem_a[pre_addr] <= pre_data;
    else if (a_we) begin
      mem_a[a_addr] <= a_wdata;
      wr_a <= wr_a + 1;
    end
    a_rdata <= mem_a[a_addr];
  end

  always @(posedge clk) begin
    if (b_we) begin
      mem_b[b_addr] <= b_wdata;
      wr_b <= wr_b + 1;
    end
    b_p0    <= mem_b[b_addr];
    b_p1    <= b_p0;
    b_rdata <= b_p1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [255:0] pat(input int unsigned n, input int unsigned mul,
                                       input int unsigned add);
    logic [255:0] p;
    p = '0;
    for (int unsigned i = 0; i < n; i++) p[i*3 +: 3] = 3'((i * mul + add) % 8);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Caller raises store_req just after a negedge.
  task automatic store_a(input logic [71:0] pv);
    for (int k = 0; k <= 24; k++) begin
      tick();
      chk("st_we", 256'(a_we), 256'(1));
      chk("st_addr", 256'(a_addr), 256'(1 + k));
      chk("st_wdata", 256'(a_wdata), (k < 24) ? 256'(pv[k*3 +: 3]) : 256'(6));
      chk("st_busy", 256'(a_busy), 256'(1));
      if (k == 0) chk("st_done0", 256'(a_done), 256'(0));
    end
    tick();
    chk("st_fin_we", 256'(a_we), 256'(0));
    chk("st_fin_done", 256'(a_done), 256'(1));
    chk("st_fin_busy", 256'(a_busy), 256'(1));
    tick();
    chk("st_idle_busy", 256'(a_busy), 256'(0));
    chk("st_idle_done", 256'(a_done), 256'(1));
  endtask

  // Caller raises load_req just after a negedge.
  task automatic load_a(input logic ok, input logic [71:0] exp_sq);
    for (int j = 0; j <= 25; j++) begin
      tick();
      chk("ld_we", 256'(a_we), 256'(0));
      chk("ld_busy", 256'(a_busy), 256'(1));
      chk("ld_valid", 256'(a_valid), 256'(0));
      chk("ld_addr", 256'(a_addr), (j <= 24) ? 256'(1 + j) : 256'(25));
    end
    tick();
    chk("ld_fin_valid", 256'(a_valid), 256'(ok));
    chk("ld_fin_done", 256'(a_done), 256'(ok));
    chk("ld_fin_err", 256'(a_err), 256'(!ok));
    chk("ld_fin_sq", 256'(a_sq_out), 256'(exp_sq));
    chk("ld_fin_busy", 256'(a_busy), 256'(1));
    tick();
    chk("ld_idle_valid", 256'(a_valid), 256'(0));
    chk("ld_idle_busy", 256'(a_busy), 256'(0));
    chk("ld_idle_sq", 256'(a_sq_out), 256'(exp_sq));
    chk("ld_idle_err", 256'(a_err), 256'(!ok));
  endtask

  task automatic preload_a(input logic [11:0] ad, input logic [31:0] d);
    pre_addr = ad;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  initial begin
    logic [71:0]  pa, pb;
    logic [161:0] qa, qb;
    int w0;
    pa = 72'(pat(24, 1, 0));
    pb = 72'(pat(24, 1, 3));
    qa = 162'(pat(54, 5, 1));
    qb = 162'(pat(54, 3, 2));

    rst = 1'b1; store_req = 1'b0; load_req = 1'b0; sq_in = '0;
    b_store = 1'b0; b_load = 1'b0; b_sq_in = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    tick(); tick();
    chk("rst_we", 256'(a_we), 256'(0));
    chk("rst_addr", 256'(a_addr), 256'(0));
    chk("rst_wdata", 256'(a_wdata), 256'(0));
    chk("rst_busy", 256'(a_busy), 256'(0));
    chk("rst_done", 256'(a_done), 256'(0));
    chk("rst_err", 256'(a_err), 256'(0));
    chk("rst_sq", 256'(a_sq_out), 256'(0));
    chk("rst_valid", 256'(a_valid), 256'(0));
    rst = 1'b0;
    tick(); tick();

    // store pattern A
    sq_in = pa; store_req = 1'b1; w0 = wr_a;
    store_a(pa);
    chk("st_count", 256'(wr_a - w0), 256'(25));
    for (int i = 1; i <= 25; i++)
      chk("st_mem", 256'(mem_a[i]), (i < 25) ? 256'(pa[(i-1)*3 +: 3]) : 256'(6));

    // round trip: sq_in changed to B, load restores A
    sq_in = pb; store_req = 1'b0;
    tick();
    load_req = 1'b1; w0 = wr_a;
    load_a(1'b1, pa);
    chk("ld_nowrite", 256'(wr_a - w0), 256'(0));

    // marker mismatch
    load_req = 1'b0;
    preload_a(12'd25, 32'd7);
    tick();
    load_req = 1'b1;
    load_a(1'b0, pa);

    // store_req held through reset release must not fire
    load_req = 1'b0; store_req = 1'b1; rst = 1'b1;
    tick(); tick();
    chk("rst2_err", 256'(a_err), 256'(0));
    chk("rst2_sq", 256'(a_sq_out), 256'(0));
    rst = 1'b0; w0 = wr_a;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_busy", 256'(a_busy), 256'(0));
      chk("held_we", 256'(a_we), 256'(0));
    end
    chk("held_nowrite", 256'(wr_a - w0), 256'(0));
    store_req = 1'b0;
    tick();
    sq_in = pb; store_req = 1'b1;
    store_a(pb);
    chk("held_marker", 256'(mem_a[25]), 256'(6));

    // reset in the middle of a dump at write k=10
    store_req = 1'b0;
    preload_a(12'd25, 32'h55);
    tick();
    sq_in = pa; store_req = 1'b1; w0 = wr_a;
    for (int k = 0; k <= 10; k++) begin
      tick();
      chk("mid_addr", 256'(a_addr), 256'(1 + k));
    end
    rst = 1'b1;
    tick();
    chk("mid_we", 256'(a_we), 256'(0));
    chk("mid_addr0", 256'(a_addr), 256'(0));
    chk("mid_wdata", 256'(a_wdata), 256'(0));
    chk("mid_busy", 256'(a_busy), 256'(0));
    chk("mid_done", 256'(a_done), 256'(0));
    chk("mid_valid", 256'(a_valid), 256'(0));
    tick();
    rst = 1'b0; store_req = 1'b0;
    tick(); tick();
    chk("mid_count", 256'(wr_a - w0), 256'(11));
    chk("mid_w11", 256'(mem_a[11]), 256'(pa[30 +: 3]));
    chk("mid_marker", 256'(mem_a[25]), 256'(32'h55));

    // simultaneous edges: STORE wins; a load edge during busy is dropped
    sq_in = pb; store_req = 1'b1; load_req = 1'b1; w0 = wr_a;
    for (int k = 0; k <= 24; k++) begin
      tick();
      chk("both_we", 256'(a_we), 256'(1));
      chk("both_addr", 256'(a_addr), 256'(1 + k));
      if (k == 3) load_req = 1'b0;
      if (k == 6) load_req = 1'b1;
    end
    tick();
    chk("both_done", 256'(a_done), 256'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("both_idle_busy", 256'(a_busy), 256'(0));
      chk("both_idle_done", 256'(a_done), 256'(1));
    end
    chk("both_count", 256'(wr_a - w0), 256'(25));

    // 54 squares, base 100, read latency 3
    b_sq_in = qa; b_store = 1'b1; w0 = wr_b;
    for (int k = 0; k <= 54; k++) begin
      tick();
      chk("b_st_we", 256'(b_we), 256'(1));
      chk("b_st_addr", 256'(b_addr), 256'(100 + k));
      chk("b_st_wdata", 256'(b_wdata), (k < 54) ? 256'(qa[k*3 +: 3]) : 256'(6));
    end
    tick();
    chk("b_st_done", 256'(b_done), 256'(1));
    tick();
    chk("b_st_busy", 256'(b_busy), 256'(0));
    chk("b_st_count", 256'(wr_b - w0), 256'(55));
    b_sq_in = qb; b_store = 1'b0;
    tick();
    b_load = 1'b1;
    for (int j = 0; j <= 57; j++) begin
      tick();
      chk("b_ld_busy", 256'(b_busy), 256'(1));
      chk("b_ld_valid", 256'(b_valid), 256'(0));
      chk("b_ld_we", 256'(b_we), 256'(0));
      if (j <= 54) chk("b_ld_addr", 256'(b_addr), 256'(100 + j));
    end
    tick();
    chk("b_fin_valid", 256'(b_valid), 256'(1));
    chk("b_fin_sq", 256'(b_sq_out), 256'(qa));
    chk("b_fin_err", 256'(b_err), 256'(0));
    chk("b_fin_done", 256'(b_done), 256'(1));
    tick();
    chk("b_idle_valid", 256'(b_valid), 256'(0));
    chk("b_idle_busy", 256'(b_busy), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
